// File: rtl/dff_share_pkg.sv
// Shared types and constants for the dff_share_arbiter slice.
package dff_share_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX_HOLD = 4;

    // Bit width needed to index n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dff_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', with wrap.
module rr_pick
    import dff_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PW      = clog2_min1(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      last,
    output logic [PW-1:0]      winner,
    output logic               valid
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        winner = '0;
        valid  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int idx;
            idx = (int'(last) + i) % NUM_REQ;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register between NUM_REQ requesters,
// with bounded locked bursts and a one-cycle IDLE bubble between grants.
module dff_share_arbiter
    import dff_share_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         lock,
    input  logic [NUM_REQ*WIDTH-1:0]   wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [clog2_min1(NUM_REQ)-1:0] owner,
    output logic                       busy,
    output logic                       ack,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           qbar
);

    localparam int PW = clog2_min1(NUM_REQ);
    localparam int HW = clog2_min1(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [PW-1:0]        last_q, last_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic                 busy_q, busy_d;
    logic                 ack_q, ack_d;
    logic [WIDTH-1:0]     q_q, q_d;

    logic [PW-1:0]        pick_winner;
    logic                 pick_valid;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr_pick (
        .req    (req),
        .last   (last_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        q_d     = q_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_winner;
                    owner_d = pick_winner;
                    last_d  = pick_winner;
                    hold_d  = '0;
                    busy_d  = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // A dropped request aborts the grant without touching the register.
                if (req[owner_q]) begin
                    q_d   = wdata[int'(owner_q)*WIDTH +: WIDTH];
                    ack_d = 1'b1;
                end
                if (req[owner_q] && lock[owner_q] && (hold_q < HOLD_LAST)) begin
                    hold_d = hold_q + 1'b1;
                end else begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= PW'(NUM_REQ - 1);
            hold_q  <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = busy_q;
    assign ack   = ack_q;
    assign q     = q_q;
    assign qbar  = ~q_q;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Directed bench for dff_share_arbiter; every ack'd write is matched against a queue
// of expected (owner, data) pairs pushed when the stimulus is driven.
module tb_dff_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic        ack;
    logic [7:0]  q;
    logic [7:0]  qbar;

    typedef struct packed {
        logic [1:0] own;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    dff_share_arbiter #(
        .NUM_REQ  (4),
        .WIDTH    (8),
        .MAX_HOLD (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .lock  (lock),
        .wdata (wdata),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy),
        .ack   (ack),
        .q     (q),
        .qbar  (qbar)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [1:0] o, input logic [7:0] d);
        exp_t e;
        e.own  = o;
        e.data = d;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: ack is stable across a whole cycle, so the negedge sees each pulse once.
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $error("FAIL sb_unexpected_ack: observed q=%0h owner=%0d expected no write", q, owner);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_q", {24'd0, q}, {24'd0, e.data});
                check("sb_owner", {30'd0, owner}, {30'd0, e.own});
                check("sb_qbar", {24'd0, qbar}, {24'd0, ~e.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        req   = '0;
        lock  = '0;
        wdata = '0;
        tick();
        tick();
        check("rst_gnt",   {28'd0, gnt},   32'h0);
        check("rst_owner", {30'd0, owner}, 32'h0);
        check("rst_busy",  {31'd0, busy},  32'h0);
        check("rst_ack",   {31'd0, ack},   32'h0);
        check("rst_q",     {24'd0, q},     32'h00);
        check("rst_qbar",  {24'd0, qbar},  32'hFF);
        rst = 1'b0;

        // Single write from requester 2.
        req = 4'b0100;
        wdata[23:16] = 8'h3C;
        push(2'd2, 8'h3C);
        tick();
        check("single_gnt",   {28'd0, gnt},   32'b0100);
        check("single_owner", {30'd0, owner}, 32'd2);
        check("single_busy",  {31'd0, busy},  32'h1);
        check("single_ack0",  {31'd0, ack},   32'h0);
        tick();
        check("single_q",     {24'd0, q},     32'h3C);
        check("single_ack",   {31'd0, ack},   32'h1);
        check("single_rel",   {28'd0, gnt},   32'h0);
        req = '0;
        tick();
        check("idle_ack_clr", {31'd0, ack},   32'h0);
        check("idle_owner",   {30'd0, owner}, 32'd2);

        // Abort: requester 3 drops its request in the grant cycle.
        req = 4'b1000;
        wdata[31:24] = 8'hEE;
        tick();
        check("abort_gnt", {28'd0, gnt}, 32'b1000);
        req = '0;
        tick();
        check("abort_ack",  {31'd0, ack},  32'h0);
        check("abort_q",    {24'd0, q},    32'h3C);
        check("abort_gnt0", {28'd0, gnt},  32'h0);
        check("abort_busy", {31'd0, busy}, 32'h0);

        // Reset in the middle of a locked burst by requester 2.
        req  = 4'b0100;
        lock = 4'b0100;
        wdata[23:16] = 8'hA5;
        tick();
        check("mid_gnt", {28'd0, gnt}, 32'b0100);
        push(2'd2, 8'hA5);
        tick();
        check("mid_busy", {31'd0, busy}, 32'h1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_gnt",   {28'd0, gnt},   32'h0);
        check("arst_busy",  {31'd0, busy},  32'h0);
        check("arst_ack",   {31'd0, ack},   32'h0);
        check("arst_q",     {24'd0, q},     32'h00);
        check("arst_qbar",  {24'd0, qbar},  32'hFF);
        check("arst_owner", {30'd0, owner}, 32'h0);
        req  = '0;
        lock = '0;
        tick();
        rst = 1'b0;

        // Round-robin with all requests held.
        req   = 4'b1111;
        wdata = 32'h13121110;
        for (int k = 0; k < 5; k++) begin
            logic [1:0] o;
            o = 2'(k % 4);
            tick();
            check("rr_gnt",   {28'd0, gnt},   32'(4'b0001 << o));
            check("rr_owner", {30'd0, owner}, {30'd0, o});
            push(o, 8'h10 + 8'(o));
            tick();
            check("rr_ack",   {31'd0, ack},   32'h1);
            check("rr_bubble", {28'd0, gnt},  32'h0);
        end
        req = '0;
        tick();

        // Burst limit: requester 1 locked, data changes every cycle.
        req  = 4'b0010;
        lock = 4'b0010;
        wdata = 32'h0;
        wdata[15:8] = 8'h01;
        tick();
        check("burst_gnt", {28'd0, gnt}, 32'b0010);
        for (int n = 1; n <= 4; n++) begin
            wdata[15:8] = 8'(n);
            push(2'd1, 8'(n));
            tick();
            check("burst_ack", {31'd0, ack}, 32'h1);
            check("burst_q",   {24'd0, q},   32'(n));
        end
        check("burst_rel_gnt",  {28'd0, gnt},  32'h0);
        check("burst_rel_busy", {31'd0, busy}, 32'h0);
        req = 4'b0011;
        wdata[15:8] = 8'h05;
        wdata[7:0]  = 8'hAA;
        tick();
        check("burst_next_gnt", {28'd0, gnt}, 32'b0001);
        check("burst_next_ack", {31'd0, ack}, 32'h0);
        push(2'd0, 8'hAA);
        tick();
        lock = '0;
        tick();
        check("burst_regnt", {28'd0, gnt}, 32'b0010);
        push(2'd1, 8'h05);
        tick();
        req = '0;
        tick();

        // Contention after burst: requester 0 locked against requester 1.
        req   = 4'b0011;
        lock  = 4'b0001;
        wdata[7:0]  = 8'hC0;
        wdata[15:8] = 8'hD1;
        tick();
        check("cont_gnt0", {28'd0, gnt}, 32'b0001);
        for (int n = 0; n < 4; n++) begin
            push(2'd0, 8'hC0);
            tick();
            check("cont_ack", {31'd0, ack}, 32'h1);
        end
        check("cont_rel", {28'd0, gnt}, 32'h0);
        push(2'd1, 8'hD1);
        tick();
        check("cont_gnt1",  {28'd0, gnt},   32'b0010);
        check("cont_owner", {30'd0, owner}, 32'd1);
        tick();
        req = '0;
        tick();
        tick();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
